seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider_pkg.sv | 13 +
 rtl/ripple_borrow_subtractor.sv | 24 ++
 rtl/seq_restoring_divider.sv | 134 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared constants and FSM encoding for the restoring divider
package seq_restoring_divider_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_D = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// rtl/ripple_borrow_subtractor.sv - W-bit ripple-borrow subtractor built from full-subtractor cells
module ripple_borrow_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  // One full-subtractor cell per bit; the borrow ripples from bit 0 upward.
  always_comb begin : chain
    logic brw;
    brw  = bin;
    diff = '0;
    for (int i = 0; i < W; i++) begin
      diff[i] = a[i] ^ b[i] ^ brw;
      brw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
    end
    bout = brw;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int D = DEF_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [D-1:0]  dvs_q, dvs_d;
  logic [D:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [D-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [D:0]    r_shift;
  logic [D:0]    trial;
  logic          borrow;
  logic          unused_r_top;

  // Dividend is shifted left each step so its MSB is always the next bit to bring down.
  assign r_shift      = {r_q[D-1:0], dvd_q[N-1]};
  // After any step R < divisor, so the top bit of R never feeds the next step.
  assign unused_r_top = r_q[D];

  ripple_borrow_subtractor #(
    .W(D + 1)
  ) u_sub (
    .a    (r_shift),
    .b    ({1'b0, dvs_q}),
    .bin  (1'b0),
    .diff (trial),
    .bout (borrow)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            dvd_d   = dividend;
            dvs_d   = divisor;
            r_d     = '0;
            q_d     = '0;
            cnt_d   = '0;
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
          end
        end
      end

      ST_RUN: begin
        dvd_d = {dvd_q[N-2:0], 1'b0};
        r_d   = borrow ? r_shift : trial;
        q_d   = {q_q[N-2:0], ~borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          quo_d   = q_d;
          rem_d   = r_d[D-1:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  seq_restoring_divider #(
    .N(8),
    .D(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of cycle 1 (start accepted at edge 0).
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
  endtask

  // Returns the cycle number in which done is seen, or -1 on timeout.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat;
    int seen;
    int bad;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);

    // 200 / 7
    launch(8'd200, 4'd7);
    check("t1_busy_c1", busy, 1);
    check("t1_done_c1", done, 0);
    wait_done(1, lat);
    check("t1_latency", lat, 9);
    check("t1_quo", quotient, 28);
    check("t1_rem", remainder, 4);
    check("t1_dbz", div_by_zero, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_quo_hold", quotient, 28);
    tick();

    // 255 / 15 then back-to-back 13 / 14
    launch(8'd255, 4'd15);
    wait_done(1, lat);
    check("t2a_latency", lat, 9);
    check("t2a_quo", quotient, 17);
    check("t2a_rem", remainder, 0);
    launch(8'd13, 4'd14);
    check("t2b_busy_c1", busy, 1);
    check("t2b_quo_clr", quotient, 0);
    wait_done(1, lat);
    check("t2b_gap", lat, 9);
    check("t2b_quo", quotient, 0);
    check("t2b_rem", remainder, 13);
    tick();

    // 100 / 0
    launch(8'd100, 4'd0);
    check("t3_done_c1", done, 1);
    check("t3_dbz", div_by_zero, 1);
    check("t3_busy_c1", busy, 0);
    check("t3_quo", quotient, 255);
    check("t3_rem", remainder, 0);
    tick();
    check("t3_done_pulse", done, 0);
    check("t3_busy_c2", busy, 0);
    check("t3_dbz_hold", div_by_zero, 1);

    // 9 / 3 with an ignored start of 50 / 5 in cycle 4
    launch(8'd9, 4'd3);
    check("t3_dbz_clr", div_by_zero, 0);
    tick();
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    tick();
    start = 1'b0;
    wait_done(5, lat);
    check("t4_latency", lat, 9);
    check("t4_quo", quotient, 3);
    check("t4_rem", remainder, 0);
    tick();

    // reset mid-operation
    launch(8'd77, 4'd4);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_quo", quotient, 0);
    check("t5_rem", remainder, 0);
    check("t5_dbz", div_by_zero, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen = 1;
      tick();
    end
    check("t5_no_done", seen, 0);
    launch(8'd77, 4'd4);
    wait_done(1, lat);
    check("t5_latency", lat, 9);
    check("t5_quo", quotient, 19);
    check("t5_rem", remainder, 1);
    tick();

    // all nonzero-divisor pairs, back-to-back
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_done(1, lat);
        if (lat != 9 || int'(quotient) * b + int'(remainder) != a ||
            int'(remainder) >= b || int'(quotient) != a / b || div_by_zero !== 1'b0) begin
          if (bad == 0)
            $display("FAIL sweep_pair: %0d/%0d got q=%0d r=%0d lat=%0d", a, b, quotient, remainder, lat);
          bad++;
        end
      end
    end
    check("sweep_bad_pairs", bad, 0);
    check("busy_done_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
